// File: rtl/i2c_req_arbiter_pkg.sv
// Shared types and defaults for the i2c request arbiter and its helpers.
package i2c_pkg;

    localparam int ADDR_W                = 7;
    localparam int DEFAULT_START_TIMEOUT = 16;
    localparam int DEFAULT_BUSY_TIMEOUT  = 65535;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RELEASE
    } state_t;

    // Width of a counter able to hold the larger of two terminal counts.
    function automatic int timer_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/i2c_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt_next,
    output logic [PW-1:0]    winner
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic               found;
    int                 sum;

    // Rotating a doubled copy puts the pointer position at bit 0.
    assign req_dbl = {req, req};
    assign req_rot = N_REQ'(req_dbl >> ptr);

    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                sum   = int'(ptr) + k;
                if (sum >= N_REQ)
                    sum = sum - N_REQ;
                winner = PW'(sum);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign gnt_next[gi] = found && (winner == PW'(gi));
        end
    endgenerate

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one i2c_master between N_REQ requesters with round-robin grant,
// busy-handshake tracking and per-requester done/err pulses.
module i2c_req_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT,
    parameter int BUSY_TIMEOUT  = DEFAULT_BUSY_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [ADDR_W*N_REQ-1:0] req_addr,
    input  logic [N_REQ-1:0]        req_rw,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        err,
    output logic                    m_start,
    output logic [ADDR_W-1:0]       m_addr,
    output logic                    m_rw,
    input  logic                    m_busy,
    output logic                    idle
);

    localparam int TW = timer_width(START_TIMEOUT, BUSY_TIMEOUT);
    localparam int PW = $clog2(N_REQ);
    localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] BUSY_LAST  = TW'(BUSY_TIMEOUT - 1);

    logic [ADDR_W-1:0] addr_slice [N_REQ];
    logic [N_REQ-1:0]  arb_gnt;
    logic [PW-1:0]     arb_winner;

    state_t            state_reg;
    logic [PW-1:0]     ptr_reg;
    logic [PW-1:0]     winner_reg;
    logic [TW-1:0]     timer_reg;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
            assign addr_slice[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr (
        .req      (req),
        .ptr      (ptr_reg),
        .gnt_next (arb_gnt),
        .winner   (arb_winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            winner_reg <= '0;
            timer_reg  <= '0;
            gnt        <= '0;
            done       <= '0;
            err        <= '0;
            m_start    <= 1'b0;
            m_addr     <= '0;
            m_rw       <= 1'b0;
            idle       <= 1'b1;
        end else begin
            done    <= '0;
            err     <= '0;
            m_start <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // A busy master here belongs to someone else; hold off.
                    if ((arb_gnt != '0) && !m_busy) begin
                        gnt        <= arb_gnt;
                        winner_reg <= arb_winner;
                        m_addr     <= addr_slice[arb_winner];
                        m_rw       <= req_rw[arb_winner];
                        m_start    <= 1'b1;
                        idle       <= 1'b0;
                        state_reg  <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_reg <= '0;
                    state_reg <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (m_busy) begin
                        timer_reg <= '0;
                        state_reg <= WAIT_DONE;
                    end else if (timer_reg == START_LAST) begin
                        err       <= gnt;
                        state_reg <= RELEASE;
                    end else if (timer_reg != '1) begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!m_busy) begin
                        done      <= gnt;
                        state_reg <= RELEASE;
                    end else if (timer_reg == BUSY_LAST) begin
                        err       <= gnt;
                        state_reg <= RELEASE;
                    end else if (timer_reg != '1) begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                RELEASE: begin
                    gnt       <= '0;
                    ptr_reg   <= (winner_reg == PW'(N_REQ - 1)) ? '0 : winner_reg + 1'b1;
                    idle      <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    gnt       <= '0;
                    idle      <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomized self-checking bench for i2c_req_arbiter against a transaction-level model.
module tb_i2c_req_arbiter;

    localparam int N  = 4;
    localparam int ST = 16;
    localparam int BT = 100;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [7*N-1:0] req_addr;
    logic [N-1:0]  req_rw;
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic [N-1:0]  err;
    logic          m_start;
    logic [6:0]    m_addr;
    logic          m_rw;
    logic          m_busy;
    logic          idle;

    int n_checks = 0;
    int n_pass   = 0;
    int model_ptr = 0;
    int txn_no = 0;

    i2c_req_arbiter #(
        .N_REQ         (N),
        .START_TIMEOUT (ST),
        .BUSY_TIMEOUT  (BT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_addr (req_addr),
        .req_rw   (req_rw),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .m_start  (m_start),
        .m_addr   (m_addr),
        .m_rw     (m_rw),
        .m_busy   (m_busy),
        .idle     (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic int model_pick(input int ptr, input logic [N-1:0] r);
        for (int off = 0; off < N; off++) begin
            if (r[(ptr + off) % N])
                return (ptr + off) % N;
        end
        return -1;
    endfunction

    // Master model: busy rises after s edges past the grant and stays high h cycles
    // (h == 0: never rises). Outcome and pulse edge follow from the timeout rules.
    task automatic run_txn(input logic [N-1:0] r, input logic [7*N-1:0] a, input logic [N-1:0] w,
                           input int s, input int h, input int foreign, input bit scramble,
                           output logic [N-1:0] obs_gnt);
        int         win;
        logic [6:0] ea;
        logic       ew;
        logic [N-1:0] oh;
        int         pulse;
        bit         is_err;
        win = model_pick(model_ptr, r);
        ea  = a[win*7 +: 7];
        ew  = w[win];
        oh  = N'(1) << win;
        check_val("pre_idle", 32'(idle), 32'd1);
        req = r; req_addr = a; req_rw = w;
        if (foreign > 0) begin
            m_busy = 1'b1;
            repeat (foreign) begin
                @(posedge clk); #1;
                check_val("foreign_gnt", 32'(gnt), 32'd0);
                check_val("foreign_idle", 32'(idle), 32'd1);
            end
            m_busy = 1'b0;
        end
        @(posedge clk); #1;
        obs_gnt = gnt;
        check_val("grant", 32'(gnt), 32'(oh));
        check_val("m_start", 32'(m_start), 32'd1);
        check_val("m_addr", 32'(m_addr), 32'(ea));
        check_val("m_rw", 32'(m_rw), 32'(ew));
        check_val("busy_idle", 32'(idle), 32'd0);
        if (scramble) begin
            req = '0; req_addr = ~a; req_rw = ~w;
        end
        if (h == 0 || s > ST) begin
            is_err = 1'b1; pulse = 1 + ST;
        end else if (h > BT) begin
            is_err = 1'b1; pulse = s + 1 + BT;
        end else begin
            is_err = 1'b0; pulse = s + 1 + h;
        end
        for (int n = 1; n <= pulse + 1; n++) begin
            @(posedge clk); #1;
            check_val("start_low", 32'(m_start), 32'd0);
            if (n < pulse) begin
                check_val("no_pulse", 32'({done, err}), 32'd0);
                check_val("gnt_hold", 32'(gnt), 32'(oh));
                check_val("addr_hold", 32'(m_addr), 32'(ea));
            end else if (n == pulse) begin
                check_val("done", 32'(done), is_err ? 32'd0 : 32'(oh));
                check_val("err", 32'(err), is_err ? 32'(oh) : 32'd0);
                check_val("gnt_at_pulse", 32'(gnt), 32'(oh));
            end else begin
                check_val("release_gnt", 32'(gnt), 32'd0);
                check_val("release_idle", 32'(idle), 32'd1);
                check_val("release_pulse", 32'({done, err}), 32'd0);
            end
            m_busy = (n >= s) && (n < s + h) && (n < pulse);
        end
        model_ptr = (win + 1) % N;
        txn_no++;
        $display("txn %0d: req=%b winner=%0d addr=%h rw=%0d s=%0d h=%0d foreign=%0d -> %s at +%0d",
                 txn_no, r, win, ea, ew, s, h, foreign, is_err ? "err" : "done", pulse);
    endtask

    logic [N-1:0]   g;
    logic [7*N-1:0] ra;
    int             exp_rr [5] = '{0, 1, 2, 3, 0};
    int             win_rst;

    initial begin
        rst_n = 1'b0; req = '0; req_addr = '0; req_rw = '0; m_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_gnt", 32'(gnt), 32'd0);
        check_val("rst_pulses", 32'({done, err, m_start}), 32'd0);
        check_val("rst_maddr", 32'({m_addr, m_rw}), 32'd0);
        check_val("rst_idle", 32'(idle), 32'd1);
        @(negedge clk); rst_n = 1'b1;

        // Round-robin with everyone requesting
        for (int i = 0; i < 5; i++) begin
            run_txn(4'b1111, 28'($urandom), 4'($urandom), 2, 3, 0, 1'b0, g);
            check_val("rr_order", 32'(g), 32'(1) << exp_rr[i]);
        end
        // Start timeout on requester 0
        run_txn(4'b0001, 28'($urandom), 4'b0000, 1, 0, 0, 1'b0, g);
        // Single request, slice 1 = 0x50, read, busy for 5 cycles
        ra = 28'($urandom);
        ra[13:7] = 7'h50;
        run_txn(4'b0010, ra, 4'b0010, 1, 5, 0, 1'b0, g);
        // Busy stuck high
        run_txn(4'b0100, 28'($urandom), 4'($urandom), 2, 1000, 0, 1'b0, g);
        // Request dropped and address changed after grant
        run_txn(4'b1000, 28'($urandom), 4'($urandom), 3, 4, 0, 1'b1, g);
        // Foreign transaction in progress
        run_txn(4'b0001, 28'($urandom), 4'($urandom), 1, 2, 3, 1'b0, g);
        // Edges of both timeout windows
        run_txn(4'b0011, 28'($urandom), 4'($urandom), ST, 2, 0, 1'b0, g);
        run_txn(4'b0110, 28'($urandom), 4'($urandom), 1, BT, 0, 1'b0, g);
        run_txn(4'b0110, 28'($urandom), 4'($urandom), 1, BT + 1, 0, 1'b0, g);

        for (int i = 0; i < 30; i++) begin
            int mode;
            int s;
            int h;
            logic [N-1:0] r;
            r = 4'($urandom_range(1, 15));
            mode = $urandom_range(0, 9);
            s = $urandom_range(1, 6);
            if (mode == 0)      h = 0;
            else if (mode == 1) h = $urandom_range(BT + 1, BT + 5);
            else                h = $urandom_range(1, 8);
            run_txn(r, 28'($urandom), 4'($urandom), s, h,
                    ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0,
                    1'($urandom), g);
        end

        // Asynchronous reset during WAIT_DONE
        req = 4'b0001; req_addr = 28'($urandom); req_rw = 4'b0001;
        win_rst = model_pick(model_ptr, req);
        @(posedge clk); #1;
        check_val("rst_txn_gnt", 32'(gnt), 32'(1) << win_rst);
        m_busy = 1'b1;
        repeat (4) @(posedge clk);
        #3; rst_n = 1'b0; #1;
        check_val("arst_gnt", 32'(gnt), 32'd0);
        check_val("arst_pulses", 32'({done, err, m_start}), 32'd0);
        check_val("arst_maddr", 32'({m_addr, m_rw}), 32'd0);
        check_val("arst_idle", 32'(idle), 32'd1);
        @(posedge clk); #1;
        check_val("arst_hold", 32'({gnt, done, err}), 32'd0);
        m_busy = 1'b0; req = '0;
        @(negedge clk); rst_n = 1'b1;
        model_ptr = 0;
        run_txn(4'b1100, 28'($urandom), 4'($urandom), 1, 3, 0, 1'b0, g);
        check_val("ptr_after_rst", 32'(g), 32'b0100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
